// File: rtl/scan_sequencer.sv
// scan_sequencer: prescaled 0..7 position scanner producing the
// 3-bit select code for a downstream 3-to-8 one-hot decoder.
module scan_sequencer #(
   parameter int DIV   = 50000,
   parameter int DIV_W = 16
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       EN,
   input  logic [1:0] MODE,
   input  logic       START,
   input  logic       LOAD,
   input  logic [2:0] LOAD_VAL,
   output logic       SEL_A,
   output logic       SEL_B,
   output logic       SEL_C,
   output logic       TICK,
   output logic       BUSY,
   output logic       DONE
);

   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] RUN   = 2'b01;
   localparam logic [1:0] SWEEP = 2'b10;

   localparam logic [1:0] M_UP     = 2'b00;
   localparam logic [1:0] M_DOWN   = 2'b01;
   localparam logic [1:0] M_BOUNCE = 2'b10;

   localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

   logic [1:0]       state;
   logic [2:0]       pos;
   logic             dir_up;
   logic [DIV_W-1:0] presc;
   logic [2:0]       cnt;
   logic             done_q;

   logic             busy;
   logic             tick;
   logic [2:0]       nxt_pos;
   logic             nxt_dir;

   assign busy  = (state != IDLE);
   assign tick  = busy & (presc == LAST);

   assign BUSY  = busy;
   assign TICK  = tick;
   assign DONE  = done_q;
   assign SEL_A = pos[2];
   assign SEL_B = pos[1];
   assign SEL_C = pos[0];

   // Position/direction after one step in the current mode
   always_comb begin
      nxt_pos = pos;
      nxt_dir = dir_up;
      case (MODE)
         M_UP:   nxt_pos = pos + 3'd1;
         M_DOWN: nxt_pos = pos - 3'd1;
         M_BOUNCE: begin
            if (state == SWEEP) begin
               nxt_pos = pos + 3'd1;
            end else if (dir_up) begin
               if (pos == 3'd7) begin
                  nxt_pos = 3'd6;
                  nxt_dir = 1'b0;
               end else begin
                  nxt_pos = pos + 3'd1;
               end
            end else begin
               if (pos == 3'd0) begin
                  nxt_pos = 3'd1;
                  nxt_dir = 1'b1;
               end else begin
                  nxt_pos = pos - 3'd1;
               end
            end
         end
         default: nxt_pos = pos;
      endcase
   end

   // Sequencer state, prescaler, position and sweep bookkeeping
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= IDLE;
         pos    <= 3'd0;
         dir_up <= 1'b1;
         presc  <= '0;
         cnt    <= 3'd0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (LOAD) begin
            pos    <= LOAD_VAL;
            presc  <= '0;
            dir_up <= 1'b1;
            cnt    <= 3'd0;
            if (state == SWEEP)
               state <= IDLE;
         end else begin
            unique case (1'b1)
               (state == IDLE): begin
                  presc <= '0;
                  if (START) begin
                     state  <= SWEEP;
                     pos    <= (MODE == M_DOWN) ? 3'd7 : 3'd0;
                     dir_up <= 1'b1;
                     cnt    <= 3'd0;
                  end else if (EN) begin
                     state <= RUN;
                  end
               end
               (state == RUN): begin
                  if (tick) begin
                     pos    <= nxt_pos;
                     dir_up <= nxt_dir;
                     presc  <= '0;
                  end else begin
                     presc <= presc + 1'b1;
                  end
                  if (!EN) begin
                     state <= IDLE;
                     presc <= '0;
                  end
               end
               (state == SWEEP): begin
                  if (tick) begin
                     pos    <= nxt_pos;
                     dir_up <= nxt_dir;
                     presc  <= '0;
                     cnt    <= cnt + 3'd1;
                     if (cnt == 3'd7) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                     end
                  end else begin
                     presc <= presc + 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  presc <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: directed scenarios plus random traffic,
// checked every cycle against a behavioural model.
module tb_scan_sequencer;

   localparam int DIV = 4;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       EN = 1'b0;
   logic [1:0] MODE = 2'b00;
   logic       START = 1'b0;
   logic       LOAD = 1'b0;
   logic [2:0] LOAD_VAL = 3'd0;
   logic       SEL_A, SEL_B, SEL_C, TICK, BUSY, DONE;

   int n_cmp = 0;
   int n_bad = 0;

   // model: st 0 idle / 1 free-run / 2 sweep
   int m_st, m_pos, m_d, m_ph, m_cnt, m_done;

   scan_sequencer #(.DIV(DIV), .DIV_W(16)) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE),
      .START(START), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
      .SEL_A(SEL_A), .SEL_B(SEL_B), .SEL_C(SEL_C),
      .TICK(TICK), .BUSY(BUSY), .DONE(DONE)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [2:0] got,
                      input logic [2:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s got=%0b exp=%0b t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_pos = 0; m_d = 1; m_ph = 0; m_cnt = 0; m_done = 0;
   endtask

   function automatic bit m_tick();
      return (m_st != 0) && (m_ph == DIV - 1);
   endfunction

   task automatic model_step();
      int p;
      if (m_st == 2 && MODE == 2'b10) begin
         m_pos = (m_pos + 1) % 8;
      end else begin
         case (MODE)
            2'b00: m_pos = (m_pos + 1) % 8;
            2'b01: m_pos = (m_pos + 7) % 8;
            2'b10: begin
               p = m_pos + m_d;
               if (p > 7) begin p = 6; m_d = -1; end
               else if (p < 0) begin p = 1; m_d = 1; end
               m_pos = p;
            end
            default: ;
         endcase
      end
   endtask

   task automatic model_edge();
      bit t;
      t = m_tick();
      m_done = 0;
      if (LOAD) begin
         m_pos = LOAD_VAL; m_ph = 0; m_d = 1; m_cnt = 0;
         if (m_st == 2) m_st = 0;
      end else if (m_st == 0) begin
         m_ph = 0;
         if (START) begin
            m_st = 2; m_pos = (MODE == 2'b01) ? 7 : 0; m_d = 1; m_cnt = 0;
         end else if (EN) begin
            m_st = 1;
         end
      end else begin
         if (t) begin model_step(); m_ph = 0; end
         else m_ph++;
         if (m_st == 1 && !EN) begin m_st = 0; m_ph = 0; end
         if (m_st == 2 && t) begin
            m_cnt++;
            if (m_cnt == 8) begin m_st = 0; m_done = 1; m_ph = 0; end
         end
      end
   endtask

   task automatic check_out();
      chk("sel", {SEL_A, SEL_B, SEL_C}, 3'(m_pos));
      chk("busy", {2'b00, BUSY}, {2'b00, m_st != 0});
      chk("tick", {2'b00, TICK}, {2'b00, m_tick()});
      chk("done", {2'b00, DONE}, 3'(m_done));
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge CLK);
         model_edge();
         #1;
         check_out();
      end
   endtask

   initial begin
      model_reset();
      #3 check_out();
      @(posedge CLK);
      #1 check_out();
      RST = 1'b0;

      // free-running up scan
      EN = 1'b1; MODE = 2'b00;
      cyc(40);
      // bounce, 20+ ticks
      MODE = 2'b10;
      cyc(84);
      // down sweep
      EN = 1'b0;
      cyc(2);
      MODE = 2'b01; START = 1'b1;
      cyc(1);
      START = 1'b0;
      cyc(40);
      // up sweep aborted by LOAD on the 3rd tick
      MODE = 2'b00; START = 1'b1;
      cyc(1);
      START = 1'b0;
      cyc(11);
      chk("tick3", {2'b00, TICK}, 3'b001);
      LOAD = 1'b1; LOAD_VAL = 3'b101;
      cyc(1);
      LOAD = 1'b0;
      chk("ld_sel", {SEL_A, SEL_B, SEL_C}, 3'b101);
      chk("ld_busy", {2'b00, BUSY}, 3'b000);
      cyc(10);
      // hold mode, then stop
      EN = 1'b1; MODE = 2'b11;
      cyc(20);
      EN = 1'b0;
      cyc(10);
      // async reset mid-prescale
      EN = 1'b1; MODE = 2'b00;
      cyc(10);
      #2 RST = 1'b1;
      #1;
      model_reset();
      check_out();
      @(posedge CLK);
      #1 check_out();
      RST = 1'b0;
      EN = 1'b0;
      cyc(2);
      // START + LOAD together in idle
      START = 1'b1; LOAD = 1'b1; LOAD_VAL = 3'b110;
      cyc(1);
      START = 1'b0; LOAD = 1'b0;
      chk("sl_sel", {SEL_A, SEL_B, SEL_C}, 3'b110);
      chk("sl_busy", {2'b00, BUSY}, 3'b000);
      cyc(5);

      // random traffic
      repeat (1500) begin
         if ($urandom_range(19) == 0) EN = ~EN;
         if ($urandom_range(24) == 0) MODE = 2'($urandom_range(3));
         START = ($urandom_range(14) == 0);
         LOAD = ($urandom_range(59) == 0);
         LOAD_VAL = 3'($urandom_range(7));
         cyc(1);
      end
      START = 1'b0; LOAD = 1'b0;
      cyc(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
